// File: rtl/fir_mac_sequencer_if.sv
// Sample handshake, coefficient config port and result signals of the
// time-multiplexed FIR sequencer.
interface fir_mac_sequencer_if #(
   parameter int DATA_W = 20,
   parameter int COEF_W = 12,
   parameter int GAIN_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic [GAIN_W-1:0]        gain;
   logic                     cfg_we;
   logic [4:0]               cfg_addr;
   logic signed [COEF_W-1:0] cfg_data;
   logic                     cfg_err;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     busy;

   modport master (
      output in_valid, in_data, gain, cfg_we, cfg_addr, cfg_data,
      input  in_ready, cfg_err, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, gain, cfg_we, cfg_addr, cfg_data,
      output in_ready, cfg_err, out_valid, out_data, busy
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR for the PLL loop filter: one shared multiplier walks all
// taps of a circular history, then the sum is scaled by a gain and saturated.
module fir_mac_sequencer #(
   parameter int DATA_W  = 20,
   parameter int COEF_W  = 12,
   parameter int NTAPS   = 29,
   parameter int ACC_W   = 40,
   parameter int GAIN_W  = 8,
   parameter int SHIFT   = 0,
   parameter int SAT_LIM = 200000
) (
   input logic                clk,
   input logic                rst,
   fir_mac_sequencer_if.slave bus
);
   localparam int         PROD_W   = COEF_W + DATA_W;
   localparam int         GP_W     = ACC_W + GAIN_W + 1;
   localparam logic [4:0] LAST_TAP = 5'(NTAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SCALE, S_OUT} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [4:0]               wptr;
   logic [4:0]               k;
   logic [4:0]               rd_idx;
   logic signed [DATA_W-1:0] hist [NTAPS];
   logic signed [COEF_W-1:0] coef [NTAPS];
   logic [GAIN_W-1:0]        gain_p0;
   logic signed [PROD_W-1:0] prod_p0;
   logic signed [ACC_W-1:0]  acc_p1;
   logic signed [GP_W-1:0]   scaled_p2;
   logic                     cfg_ok;

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [GP_W-1:0] v);
      logic signed [GP_W-1:0] lim;
      lim = GP_W'(SAT_LIM);
      if (v > lim)
         sat = DATA_W'(SAT_LIM);
      else if (v < -lim)
         sat = -DATA_W'(SAT_LIM);
      else
         sat = DATA_W'(v);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.in_valid) state_nxt = S_MAC;
         S_MAC:   if (k == LAST_TAP) state_nxt = S_SCALE;
         S_SCALE: state_nxt = S_OUT;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.busy      = (state != S_IDLE);
      bus.out_valid = (state == S_OUT);
   end

   // Tap k reads the sample accepted k transactions ago: (wptr - k) mod NTAPS.
   always_comb begin
      if (wptr >= k)
         rd_idx = wptr - k;
      else
         rd_idx = 5'(6'(wptr) + 6'(NTAPS) - 6'(k));
   end

   // Stage 0: single shared multiplier.
   assign prod_p0 = PROD_W'(coef[k]) * PROD_W'(hist[rd_idx]);

   // Stage 2: gain is unsigned, so it enters the signed product zero-extended.
   assign scaled_p2 = (GP_W'(acc_p1) * GP_W'($signed({1'b0, gain_p0}))) >>> SHIFT;

   assign cfg_ok = (state == S_IDLE) && ({1'b0, bus.cfg_addr} < 6'(NTAPS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr         <= '0;
         k            <= '0;
         gain_p0      <= '0;
         acc_p1       <= '0;
         bus.out_data <= '0;
         bus.cfg_err  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            hist[i] <= '0;
            coef[i] <= '0;
         end
      end else begin
         bus.cfg_err <= 1'b0;
         if (bus.cfg_we) begin
            if (cfg_ok)
               coef[bus.cfg_addr] <= bus.cfg_data;
            else
               bus.cfg_err <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  hist[wptr] <= bus.in_data;
                  gain_p0    <= bus.gain;
                  acc_p1     <= '0;
                  k          <= '0;
               end
            end
            // Stage 1: accumulate one tap per cycle.
            S_MAC: begin
               acc_p1 <= acc_p1 + ACC_W'(prod_p0);
               if (k == LAST_TAP) begin
                  k    <= '0;
                  wptr <= (wptr == LAST_TAP) ? 5'd0 : wptr + 5'd1;
               end else begin
                  k <= k + 5'd1;
               end
            end
            S_SCALE: bus.out_data <= sat(scaled_p2);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: the driver queues expected results,
// a negedge monitor pops and compares them whenever out_valid is seen.
module tb_fir_mac_sequencer;
   localparam int DATA_W = 20;
   localparam int COEF_W = 12;
   localparam int GAIN_W = 8;

   typedef struct {
      string name;
      int    act;
      int    req;
   } chk_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   exp_q[$];
   int   stamp_q[$];
   int   acc_log[$];
   chk_t chk_q[$];
   bit   hs_mode = 1'b0;
   int   hs_viol = 0;

   fir_mac_sequencer_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .GAIN_W(GAIN_W)) bus ();

   fir_mac_sequencer #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(29), .ACC_W(40),
      .GAIN_W(GAIN_W), .SHIFT(0), .SAT_LIM(200000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void do_check(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endfunction

   function automatic void req_check(string name, int act, int req);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.req  = req;
      chk_q.push_back(c);
   endfunction

   // Monitor: the only process that steps the counters.
   always @(negedge clk) begin : mon
      chk_t c;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         do_check(c.name, c.act, c.req);
      end
      if (!rst) begin
         stamp_q.delete();
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            stamp_q.push_back(cyc);
            acc_log.push_back(cyc);
         end else if (hs_mode && !(bus.in_ready == 1'b0 && bus.busy == 1'b1)) begin
            hs_viol++;
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0)
               do_check("unexpected_out_valid", int'(bus.out_data), 0 - 999999);
            else
               do_check("out_data", int'(bus.out_data), exp_q.pop_front());
            if (stamp_q.size() == 0)
               do_check("latency_no_accept", 0, 1);
            else
               do_check("latency", cyc - stamp_q.pop_front(), 31);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(string tag);
      int g = 0;
      while (!bus.in_ready && g < 200) begin
         tick();
         g++;
      end
      if (!bus.in_ready) req_check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_log(int n);
      int g = 0;
      while (acc_log.size() < n && g < 200) begin
         tick();
         g++;
      end
      if (acc_log.size() < n) req_check("hs_accept_timeout", acc_log.size(), n);
   endtask

   task automatic write_coef(int addr, int data);
      wait_idle("wcoef");
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'(addr);
      bus.cfg_data = 12'(data);
      tick();
      bus.cfg_we = 1'b0;
      req_check("cfg_err_good_write", int'(bus.cfg_err), 0);
   endtask

   task automatic send(int data, int g, int expv);
      wait_idle("send");
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(data);
      bus.gain     = 8'(g);
      exp_q.push_back(expv);
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.gain     = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      #2 rst = 1'b0;
      repeat (3) tick();
      req_check("rst_busy", int'(bus.busy), 0);
      req_check("rst_out_valid", int'(bus.out_valid), 0);
      req_check("rst_out_data", int'(bus.out_data), 0);
      req_check("rst_cfg_err", int'(bus.cfg_err), 0);
      rst = 1'b1;
      tick();
      req_check("rel_in_ready", int'(bus.in_ready), 1);
      req_check("rel_busy", int'(bus.busy), 0);
      repeat (10) tick();
      req_check("idle_out_data", int'(bus.out_data), 0);

      // Impulse response through ramp coefficients.
      for (int i = 0; i < 29; i++) write_coef(i, i + 1);
      send(1000, 1, 1000);
      for (int n = 1; n < 29; n++) send(0, 1, (n + 1) * 1000);
      send(0, 1, 0);

      // Saturation.
      write_coef(0, 100);
      for (int i = 1; i < 29; i++) write_coef(i, 0);
      send(300, 10, 200000);
      send(-300, 10, -200000);
      send(150, 10, 150000);
      send(200, 10, 200000);
      send(-201, 10, -200000);

      // Back-to-back accepts with in_valid held; gain change after accept.
      write_coef(0, 1);
      wait_idle("hs");
      acc_log.delete();
      bus.in_valid = 1'b1;
      bus.in_data  = 20'sd10;
      bus.gain     = 8'd1;
      exp_q.push_back(10);
      exp_q.push_back(100);
      exp_q.push_back(150);
      wait_log(1);
      hs_mode = 1'b1;
      bus.in_data = 20'sd20;
      repeat (5) tick();
      bus.gain = 8'd5;
      wait_log(2);
      bus.in_data = 20'sd30;
      wait_log(3);
      bus.in_valid = 1'b0;
      hs_mode = 1'b0;
      if (acc_log.size() == 3) begin
         req_check("hs_gap_1", acc_log[1] - acc_log[0], 32);
         req_check("hs_gap_2", acc_log[2] - acc_log[1], 32);
      end else begin
         req_check("hs_accept_count", acc_log.size(), 3);
      end
      req_check("hs_ready_busy_viol", hs_viol, 0);

      // Config write while busy is rejected.
      send(40, 1, 40);
      repeat (2) tick();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'd0;
      bus.cfg_data = 12'sd7;
      tick();
      bus.cfg_we = 1'b0;
      req_check("cfg_err_busy", int'(bus.cfg_err), 1);
      tick();
      req_check("cfg_err_busy_end", int'(bus.cfg_err), 0);
      send(3, 1, 3);

      // Out-of-range address in IDLE is rejected.
      wait_idle("badaddr");
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'd29;
      bus.cfg_data = 12'sd9;
      tick();
      bus.cfg_we = 1'b0;
      req_check("cfg_err_addr29", int'(bus.cfg_err), 1);
      tick();
      req_check("cfg_err_addr29_end", int'(bus.cfg_err), 0);
      send(5, 1, 5);

      // Reset in the middle of MAC.
      write_coef(1, 2);
      wait_idle("midrst");
      bus.in_valid = 1'b1;
      bus.in_data  = 20'sd7;
      bus.gain     = 8'd1;
      tick();
      bus.in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b0;
      #1;
      req_check("midrst_out_data", int'(bus.out_data), 0);
      req_check("midrst_busy", int'(bus.busy), 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      send(50, 1, 0);
      write_coef(0, 3);
      write_coef(1, 0);
      for (int i = 2; i < 29; i++) write_coef(i, 1);
      send(50, 1, 150);

      wait_idle("final");
      repeat (3) tick();
      req_check("exp_q_drained", exp_q.size(), 0);
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR controller for the PLL loop-filter path.
- Accepts one sample per valid/ready handshake and stores it in a circular history buffer.
- Runs a single shared multiply-accumulate over all taps, one tap per cycle, then applies a gain and symmetric saturation.
- Coefficients are runtime-writable through a config port. This replaces the fully parallel 29-multiplier filter with one multiplier.

Parameters:
- DATA_W, 20, sample and output width, signed two's complement
- COEF_W, 12, coefficient width, signed
- NTAPS, 29, number of taps (2..32)
- ACC_W, 40, accumulator width, signed
- GAIN_W, 8, gain width, unsigned
- SHIFT, 0, arithmetic right shift applied after gain
- SAT_LIM, 200000, saturation magnitude (must be < 2^(DATA_W-1))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  signed input sample
- gain  in  GAIN_W  unsigned gain; sampled on accept
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  5  tap index
- cfg_data  in  COEF_W  signed coefficient
- cfg_err  out  1  one-cycle pulse when a write is rejected
- out_valid  out  1  one-cycle pulse when out_data is updated
- out_data  out  DATA_W  signed filtered result; held between pulses
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous (rst low). It clears:
  - state to IDLE, wptr=0, k=0, acc=0;
  - all history entries and all coefficients to 0;
  - out_valid=0, out_data=0, cfg_err=0, busy=0.
  - in_ready is 1 from reset release onward.
- Reset asserted mid-operation aborts the computation: no out_valid is produced and all history is lost.
- State machine:
  - IDLE: in_ready=1. On in_valid, accept the sample:
    - write hist[wptr]=in_data;
    - latch gain into gain_r;
    - acc=0, k=0;
    - go to MAC.
  - MAC: in_ready=0. Each cycle do acc += coef[k] * hist[(wptr-k) mod NTAPS], then k++.
    - After k=NTAPS-1 is processed: advance wptr (wrap NTAPS-1 to 0) and go to SCALE.
  - SCALE: compute p = (acc * zero-extended gain_r) >>> SHIFT.
    - Clamp p to [-SAT_LIM, +SAT_LIM].
    - Register the result into out_data and go to OUT.
  - OUT: out_valid=1 for exactly this cycle, then go to IDLE.
- Timing:
  - Accept edge = cycle 0. MAC occupies cycles 1..NTAPS. SCALE is cycle NTAPS+1. out_valid is asserted in cycle NTAPS+2 (31 for defaults).
  - The earliest next accept is cycle NTAPS+3. With in_valid held high, accepts are spaced exactly NTAPS+3 cycles apart.
- Tap ordering: tap 0 multiplies the newest sample; tap k multiplies the sample accepted k transactions earlier. Unwritten history reads as 0.
- Arithmetic:
  - Products are COEF_W+DATA_W bits signed, sign-extended into the ACC_W accumulator; no overflow is possible for the defaults.
  - The gain product is ACC_W+GAIN_W+1 bits.
  - Saturation is symmetric and never wraps or zeroes.
- Config writes:
  - Accepted only in IDLE with cfg_addr < NTAPS; the write takes effect the next cycle.
  - A write while busy, or with cfg_addr >= NTAPS, is ignored. cfg_err pulses for one cycle on the following cycle.
  - If in_valid and cfg_we occur in the same IDLE cycle, both are accepted; the new coefficient is used by this computation.
- gain and in_data changes after the accept cycle have no effect on the running computation.

Test Plan:
1. Reset -> in_ready=1, busy=0, out_valid=0, out_data=0; hold 10 cycles with in_valid=0 -> no out_valid.
2. Impulse response:
   - Stimulus: load coef[k]=k+1 for k=0..28, gain=1; send 1000 followed by 28 zeros.
   - Required: out_data sequence 1000, 2000, ..., 29000.
   - Each out_valid arrives exactly 31 cycles after its accept.
   - A 30th zero sample gives 0.
3. Saturation, with coef[0]=100 and the others 0, gain=10:
   - sample 300 -> out_data=200000;
   - sample -300 -> out_data=-200000;
   - sample 150 -> 150000.
4. Handshake and latch:
   - Stimulus: in_valid held high with 3 samples.
   - Required: accepts at cycles 0, 32, 64; in_ready=0 and busy=1 between accepts.
   - Changing gain from 1 to 5 at cycle 5 -> the first result still uses gain 1.
5. Config errors:
   - cfg_we during MAC (coef[0]=7) -> cfg_err pulse; the next result shows coef[0] unchanged.
   - cfg_we with cfg_addr=29 in IDLE -> cfg_err pulse, no coefficient change.
6. Reset mid-operation:
   - Stimulus: assert rst at MAC tap k=10.
   - Required: immediate out_data=0; no out_valid; coefficients cleared.
   - After reloading coef[0]=3, sending 50 -> out_data=150 (history cleared).
